// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared segment patterns, scan FSM state type and digit-enable
//               constants for the four-digit multiplexed display driver.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    typedef enum logic [0:0] {
        ST_ON    = 1'b0,
        ST_BLANK = 1'b1
    } seg_state_t;

    // Segment order is {a,b,c,d,e,f,g}; the dp bit is appended by the scanner.
    localparam logic [6:0] c_SEG_0    = 7'b1111110;
    localparam logic [6:0] c_SEG_1    = 7'b0110000;
    localparam logic [6:0] c_SEG_2    = 7'b1101101;
    localparam logic [6:0] c_SEG_3    = 7'b1111001;
    localparam logic [6:0] c_SEG_4    = 7'b0110011;
    localparam logic [6:0] c_SEG_5    = 7'b1011011;
    localparam logic [6:0] c_SEG_6    = 7'b1011111;
    localparam logic [6:0] c_SEG_7    = 7'b1110000;
    localparam logic [6:0] c_SEG_8    = 7'b1111111;
    localparam logic [6:0] c_SEG_9    = 7'b1111011;
    localparam logic [6:0] c_SEG_DASH = 7'b0000001;
    localparam logic [6:0] c_SEG_OFF  = 7'b0000000;

    localparam logic [3:0] c_DIG_0    = 4'b1110;
    localparam logic [3:0] c_DIG_1    = 4'b1101;
    localparam logic [3:0] c_DIG_2    = 4'b1011;
    localparam logic [3:0] c_DIG_3    = 4'b0111;
    localparam logic [3:0] c_DIG_NONE = 4'b1111;

    function automatic logic [3:0] dig_enable(input logic [1:0] idx);
        logic [3:0] r;
        case (idx)
            2'd0:    r = c_DIG_0;
            2'd1:    r = c_DIG_1;
            2'd2:    r = c_DIG_2;
            default: r = c_DIG_3;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_decode
// Description : Combinational BCD nibble to 7-segment decode; 10-15 show dash.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = c_SEG_DASH;
        case (i_nib)
            4'd0:    o_seg = c_SEG_0;
            4'd1:    o_seg = c_SEG_1;
            4'd2:    o_seg = c_SEG_2;
            4'd3:    o_seg = c_SEG_3;
            4'd4:    o_seg = c_SEG_4;
            4'd5:    o_seg = c_SEG_5;
            4'd6:    o_seg = c_SEG_6;
            4'd7:    o_seg = c_SEG_7;
            4'd8:    o_seg = c_SEG_8;
            4'd9:    o_seg = c_SEG_9;
            default: o_seg = c_SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan4.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan4
// Description : Four-digit multiplexed 7-segment scanner with dead-time
//               blanking and a frame-synchronous shadow register.
//               Define SEG_SCAN_LZB_EN to blank leading zeros.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan4
    import seg_pkg::*;
#(
    parameter int SCAN_WAIT  = 27_000,
    parameter int BLANK_WAIT = 270
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_bcd,
    input  logic [3:0]  i_dp,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [7:0]  o_seg,
    output logic [3:0]  o_dig,
    output logic        o_frame
);

    localparam int c_CNT_MAX = (SCAN_WAIT > BLANK_WAIT) ? SCAN_WAIT : BLANK_WAIT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX);

    localparam logic [c_CNT_W-1:0] c_SCAN_LAST  = c_CNT_W'(SCAN_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_WAIT - 1);

    logic               w_rst;
    seg_state_t         r_state;
    logic [1:0]         r_idx;
    logic [c_CNT_W-1:0] r_cnt;
    logic [15:0]        r_act_bcd;
    logic [3:0]         r_act_dp;
    logic [15:0]        r_sh_bcd;
    logic [3:0]         r_sh_dp;
    logic               r_sh_full;
    logic [7:0]         r_seg;
    logic [3:0]         r_dig;
    logic               r_frame;

    seg_state_t         w_state_nx;
    logic [1:0]         w_idx_nx;
    logic [c_CNT_W-1:0] w_cnt_nx;
    logic               w_frame_start;
    logic               w_load;
    logic               w_capture;
    logic [15:0]        w_act_bcd_nx;
    logic [3:0]         w_act_dp_nx;
    logic [3:0]         w_nib;
    logic [6:0]         w_dec;
    logic               w_lz;
    logic [7:0]         w_seg_nx;
    logic [3:0]         w_dig_nx;

    assign w_rst = i_rst;

    always_comb begin
        w_state_nx    = r_state;
        w_idx_nx      = r_idx;
        w_cnt_nx      = r_cnt + c_CNT_W'(1);
        w_frame_start = 1'b0;
        case (r_state)
            ST_ON: begin
                if (r_cnt == c_SCAN_LAST) begin
                    w_state_nx = ST_BLANK;
                    w_cnt_nx   = '0;
                end
            end
            default: begin
                if (r_cnt == c_BLANK_LAST) begin
                    w_state_nx    = ST_ON;
                    w_cnt_nx      = '0;
                    w_idx_nx      = r_idx + 2'd1;
                    w_frame_start = (r_idx == 2'd3);
                end
            end
        endcase
    end

    // Active data only changes at the frame boundary, so a frame never tears.
    assign w_load       = w_frame_start && r_sh_full;
    assign w_capture    = i_valid && !r_sh_full;
    assign w_act_bcd_nx = w_load ? r_sh_bcd : r_act_bcd;
    assign w_act_dp_nx  = w_load ? r_sh_dp  : r_act_dp;
    assign w_nib        = w_act_bcd_nx[{w_idx_nx, 2'b00} +: 4];

    seg_decode u_decode (
        .i_nib (w_nib),
        .o_seg (w_dec)
    );

`ifdef SEG_SCAN_LZB_EN
    always_comb begin
        w_lz = 1'b0;
        case (w_idx_nx)
            2'd3:    w_lz = (w_act_bcd_nx[15:12] == 4'd0);
            2'd2:    w_lz = (w_act_bcd_nx[15:8]  == 8'd0);
            2'd1:    w_lz = (w_act_bcd_nx[15:4]  == 12'd0);
            default: w_lz = 1'b0;
        endcase
    end
`else
    assign w_lz = 1'b0;
`endif

    always_comb begin
        w_seg_nx = {c_SEG_OFF, 1'b0};
        w_dig_nx = c_DIG_NONE;
        if (w_state_nx == ST_ON) begin
            w_seg_nx = {(w_lz ? c_SEG_OFF : w_dec), w_act_dp_nx[w_idx_nx]};
            w_dig_nx = dig_enable(w_idx_nx);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_rst) begin
            r_state   <= ST_ON;
            r_idx     <= 2'd0;
            r_cnt     <= '0;
            r_act_bcd <= 16'h0000;
            r_act_dp  <= 4'h0;
            r_sh_bcd  <= 16'h0000;
            r_sh_dp   <= 4'h0;
            r_sh_full <= 1'b0;
            r_seg     <= {c_SEG_0, 1'b0};
            r_dig     <= c_DIG_0;
            r_frame   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_idx     <= w_idx_nx;
            r_cnt     <= w_cnt_nx;
            r_act_bcd <= w_act_bcd_nx;
            r_act_dp  <= w_act_dp_nx;
            r_seg     <= w_seg_nx;
            r_dig     <= w_dig_nx;
            r_frame   <= w_frame_start;
            // Load needs a full shadow, capture an empty one: never both.
            if (w_load) begin
                r_sh_full <= 1'b0;
            end else if (w_capture) begin
                r_sh_bcd  <= i_bcd;
                r_sh_dp   <= i_dp;
                r_sh_full <= 1'b1;
            end
        end
    end

    assign o_ready = !r_sh_full;
    assign o_seg   = r_seg;
    assign o_dig   = r_dig;
    assign o_frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan4.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan4
// Description : Directed self-checking bench for seg_scan4 (SCAN_WAIT=4,
//               BLANK_WAIT=2, 24-cycle frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan4;

    logic        r_clk = 1'b0;
    logic        r_rst;
    logic [15:0] r_bcd;
    logic [3:0]  r_dp;
    logic        r_valid;
    logic        w_ready;
    logic [7:0]  w_seg;
    logic [3:0]  w_dig;
    logic        w_frame;

    int n_total = 0;
    int n_bad   = 0;

    seg_scan4 #(
        .SCAN_WAIT  (4),
        .BLANK_WAIT (2)
    ) u_dut (
        .i_clk   (r_clk),
        .i_rst   (r_rst),
        .i_bcd   (r_bcd),
        .i_dp    (r_dp),
        .i_valid (r_valid),
        .o_ready (w_ready),
        .o_seg   (w_seg),
        .o_dig   (w_dig),
        .o_frame (w_frame)
    );

    always #5 r_clk = ~r_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Advance at least one cycle, then stop on the next frame pulse.
    task automatic wait_frame();
        int guard;
        guard = 0;
        tick();
        while (w_frame !== 1'b1 && guard < 30) begin
            tick();
            guard++;
        end
        chk("frame_seen", {15'd0, w_frame}, 16'd1);
    endtask

    logic [7:0] e_seg1234 [4];
    logic [3:0] e_dig     [4];

    initial begin
        e_seg1234[0] = 8'b01100110;
        e_seg1234[1] = 8'b11110011;
        e_seg1234[2] = 8'b11011010;
        e_seg1234[3] = 8'b01100000;
        e_dig[0] = 4'b1110;
        e_dig[1] = 4'b1101;
        e_dig[2] = 4'b1011;
        e_dig[3] = 4'b0111;

        r_rst = 1'b1; r_bcd = 16'h0; r_dp = 4'h0; r_valid = 1'b0;
        ticks(2);
        chk("rst_dig",   {12'd0, w_dig},   16'h000E);
        chk("rst_seg",   {8'd0,  w_seg},   16'h00FC);
        chk("rst_ready", {15'd0, w_ready}, 16'd1);
        chk("rst_frame", {15'd0, w_frame}, 16'd0);
        r_rst = 1'b0;

        // Load 1234 with dp on digit 1, then check one full frame.
        r_bcd = 16'h1234; r_dp = 4'b0010; r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        chk("load_busy",  {15'd0, w_ready}, 16'd0);
        chk("load_notear",{8'd0,  w_seg},   16'h00FC);
        wait_frame();
        chk("load_ready", {15'd0, w_ready}, 16'd1);
        for (int k = 0; k < 24; k++) begin
            if ((k % 6) < 4)
                chk($sformatf("scan_%0d", k), {4'd0, w_dig, w_seg}, {4'd0, e_dig[k/6], e_seg1234[k/6]});
            else
                chk($sformatf("blank_%0d", k), {4'd0, w_dig, w_seg}, 16'h0F00);
            tick();
        end

        // Back-pressure: 1111 taken, 2222 held off until the frame boundary.
        r_bcd = 16'h1111; r_dp = 4'h0; r_valid = 1'b1;
        tick();
        chk("bp_busy1", {15'd0, w_ready}, 16'd0);
        r_bcd = 16'h2222;
        tick();
        chk("bp_busy2", {15'd0, w_ready}, 16'd0);
        wait_frame();
        chk("bp_show1",  {4'd0, w_dig, w_seg}, 16'h0E60);
        chk("bp_ready",  {15'd0, w_ready}, 16'd1);
        tick();
        r_valid = 1'b0;
        chk("bp_take2", {15'd0, w_ready}, 16'd0);
        wait_frame();
        chk("bp_show2", {4'd0, w_dig, w_seg}, 16'h0EDA);
        ticks(6);
        chk("bp_show2d1", {4'd0, w_dig, w_seg}, 16'h0DDA);

        // Invalid nibble on digit 1.
        r_bcd = 16'h00A0; r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        wait_frame();
        chk("inv_d0", {4'd0, w_dig, w_seg}, 16'h0EFC);
        ticks(6);
        chk("inv_d1", {4'd0, w_dig, w_seg}, 16'h0D02);

        // Leading zeros.
        r_bcd = 16'h0007; r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        wait_frame();
        chk("lz_d0", {4'd0, w_dig, w_seg}, 16'h0EE0);
        for (int d = 1; d < 4; d++) begin
            ticks(6);
`ifdef SEG_SCAN_LZB_EN
            chk($sformatf("lz_d%0d", d), {4'd0, w_dig, w_seg}, {4'd0, e_dig[d], 8'h00});
`else
            chk($sformatf("lz_d%0d", d), {4'd0, w_dig, w_seg}, {4'd0, e_dig[d], 8'hFC});
`endif
        end

        // Reset during BLANK of digit 2 with a full shadow register.
        wait_frame();
        r_bcd = 16'h9999; r_dp = 4'hF; r_valid = 1'b1;
        tick();
        r_valid = 1'b0;
        chk("mr_full", {15'd0, w_ready}, 16'd0);
        ticks(15);
        chk("mr_blank", {4'd0, w_dig, w_seg}, 16'h0F00);
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        chk("mr_dig",   {12'd0, w_dig},   16'h000E);
        chk("mr_seg",   {8'd0,  w_seg},   16'h00FC);
        chk("mr_ready", {15'd0, w_ready}, 16'd1);
        chk("mr_frame", {15'd0, w_frame}, 16'd0);
        wait_frame();
        chk("mr_nodata", {4'd0, w_dig, w_seg}, 16'h0EFC);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan4.md
SEG_SCAN4 -- requirements
Module: seg_scan4

Interface
REQ-001 SHALL have parameter SCAN_WAIT, default 27_000, clock cycles each digit is driven (1 ms at 27 MHz), legal >= 2.
REQ-002 SHALL have parameter BLANK_WAIT, default 270, clock cycles of all-off dead time after each digit (anti-ghosting), legal >= 1.
REQ-003 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_bcd  input  16  four BCD digits, digit3 in [15:12] ... digit0 in [3:0].
REQ-006 SHALL have port i_dp  input  4  decimal-point enable per digit, bit n = digit n.
REQ-007 SHALL have port i_valid  input  1  upstream offers i_bcd/i_dp this cycle.
REQ-008 SHALL have port o_ready  output  1  shadow register empty; transfer occurs when i_valid && o_ready.
REQ-009 SHALL have port o_seg  output  8  segment pattern {a,b,c,d,e,f,g,dp}, 1 = lit.
REQ-010 SHALL have port o_dig  output  4  digit enables, active-low, one-hot-zero or all-ones.
REQ-011 SHALL have port o_frame  output  1  one-cycle pulse on entry to digit 0 ON phase.

Function
REQ-012 SHALL run FSM with states ON and BLANK: ON lasts SCAN_WAIT cycles, then BLANK lasts BLANK_WAIT cycles, then ON for next digit index.
REQ-013 SHALL advance digit index 0->1->2->3->0 on each BLANK->ON transition; frame period = 4*(SCAN_WAIT+BLANK_WAIT) cycles.
REQ-014 SHALL in ON drive o_dig with bit[idx] = 0, others 1 (idx0 = 4'b1110, idx1 = 4'b1101, idx2 = 4'b1011, idx3 = 4'b0111).
REQ-015 SHALL in BLANK drive o_dig = 4'b1111 and o_seg = 8'b00000000.
REQ-016 SHALL decode BCD 0-9 to 11111100, 01100000, 11011010, 11110010, 01100110, 10110110, 10111110, 11100000, 11111110, 11110110; dp bit = active i_dp[idx].
REQ-017 SHALL decode nibble values 10-15 to dash 8'b00000010 (dp bit still applied).
REQ-018 SHALL derive o_seg/o_dig/o_ready/o_frame only from registers; no combinational path from inputs to outputs.
REQ-019 SHALL on i_valid && o_ready capture i_bcd/i_dp into shadow register and deassert o_ready next cycle.
REQ-020 SHALL copy shadow to active register and reassert o_ready on the cycle the FSM enters ON for idx 0, only if shadow was full before that edge.
REQ-021 SHALL, when capture and frame-start transfer coincide with shadow empty, hold the captured data in shadow until the following frame start.
REQ-022 SHALL never change active digits mid-frame (no tearing).
REQ-023 SHALL ignore i_valid while o_ready = 0; upstream holds data.

Reset
REQ-024 SHALL on i_rst: FSM = ON, idx = 0, phase counter = 0, active digits = 0, active dp = 0, shadow empty.
REQ-025 SHALL produce after reset o_dig = 4'b1110, o_seg = 8'b11111100, o_ready = 1, o_frame = 0; first o_frame pulse at first wrap to idx 0.
REQ-026 SHALL, on reset asserted mid-operation (any state), discard shadow contents and restart per REQ-024 on the next edge.

Configuration
REQ-027 SHALL with SEG_SCAN_LZB_EN defined blank leading zeros: digit n (n = 3..1) shows o_seg[7:1] = 0 when it and all higher digits equal 0; dp bit still honoured; digit 0 never blanked.
REQ-028 SHALL without SEG_SCAN_LZB_EN display every digit including leading zeros; ON timing identical in both builds.

Structure
REQ-029 SHALL place segment constants (digit 0-9 patterns, dash, off), FSM state type and digit-enable constants in shared package seg_pkg.
REQ-030 SHALL implement nibble-to-segment decode as sub-module seg_decode (combinational, 4-bit in, 7-bit out); counter widths derived via $clog2 of parameters.

Verification (SCAN_WAIT = 4, BLANK_WAIT = 2, frame = 24 cycles)
REQ-031 SHALL cover reset: hold i_rst 2 cycles -> o_dig = 1110, o_seg = 11111100, o_ready = 1, o_frame = 0.
REQ-032 SHALL cover load/scan: i_bcd = 16'h1234, i_dp = 4'b0010 -> after next o_frame: 1110/01100110 x4, 1111/00000000 x2, 1101/11110011 x4, then 1011/11011010, 0111/01100000.
REQ-033 SHALL cover back-pressure: two back-to-back offers 16'h1111 then 16'h2222 -> second held with o_ready = 0 until frame start, shows on frame after 16'h1111.
REQ-034 SHALL cover invalid nibble: i_bcd = 16'h00A0 -> digit1 o_seg = 00000010.
REQ-035 SHALL cover LZB: i_bcd = 16'h0007 -> with SEG_SCAN_LZB_EN digits 3..1 o_seg = 00000000, digit0 11100000; without, digits 3..1 = 11111100.
REQ-036 SHALL cover reset mid-BLANK of idx 2 with shadow full -> next cycle o_dig = 1110, o_seg = 11111100, o_ready = 1, shadow data never displayed.
